// File: rtl/pipe_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit_pkg : state encodings and defaults for pipeline control
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_unit_pkg;

  localparam int PIPE_CTRL_STATE_WIDTH = 2;
  localparam int DEFAULT_NUM_STAGES    = 5;

  typedef enum logic [PIPE_CTRL_STATE_WIDTH-1:0] {
    RST_WAIT = 2'd0,
    RST_HOLD = 2'd1,
    RUN      = 2'd2,
    HALT     = 2'd3
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_unit_sync_2ff.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit_sync_2ff : WIDTH-bit two-flop synchroniser, async reset to 0
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl_unit_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit : reset sequencing, stall/flush/redirect and halt control
// Optional perf counters under macro PIPE_CTRL_PERF_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int NUM_STAGES      = DEFAULT_NUM_STAGES,
  parameter int RST_HOLD_CYCLES = 4
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int PERF_W          = 32
`endif
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          pll_locked_i,
  input  logic [NUM_STAGES-1:0]         stall_req_i,
  input  logic                          redirect_valid_i,
  input  logic [$clog2(NUM_STAGES)-1:0] redirect_stage_i,
  input  logic                          halt_req_i,
  output logic                          core_reset_o,
  output logic [NUM_STAGES-1:0]         stage_en_o,
  output logic [NUM_STAGES-1:0]         stage_flush_o,
  output logic [PIPE_CTRL_STATE_WIDTH-1:0] ctrl_state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]             perf_cycles_o,
  output logic [PERF_W-1:0]             perf_stalls_o,
  output logic [PERF_W-1:0]             perf_flushes_o
`endif
);

  localparam int SW = $clog2(NUM_STAGES);
  localparam int CW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(RST_HOLD_CYCLES - 1);

  logic        lock_s;
  ctrl_state_e state_q;
  logic        core_reset_q;
  logic [CW-1:0] hold_cnt_q;

  pipe_ctrl_unit_sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pll_locked_i),
    .q_o    (lock_s)
  );

  // Lock loss overrides every state, including HALT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RST_WAIT;
      core_reset_q <= 1'b1;
      hold_cnt_q   <= '0;
    end else if (!lock_s) begin
      state_q      <= RST_WAIT;
      core_reset_q <= 1'b1;
      hold_cnt_q   <= '0;
    end else begin
      case (state_q)
        RST_WAIT: begin
          state_q      <= RST_HOLD;
          core_reset_q <= 1'b1;
          hold_cnt_q   <= '0;
        end
        RST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q      <= RUN;
            core_reset_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (halt_req_i) state_q <= HALT;
        end
        HALT: state_q <= HALT;
        default: begin
          state_q      <= RST_WAIT;
          core_reset_q <= 1'b1;
        end
      endcase
    end
  end

  // A RUN cycle with lock already lost is treated as idle so no flush escapes.
  logic                  run_active;
  logic [SW-1:0]         redir_stage;
  logic                  redir_accept;
  logic [NUM_STAGES-1:0] stall_en;
  logic [NUM_STAGES-1:0] redir_mask;
  logic [NUM_STAGES-1:0] en_w;
  logic [NUM_STAGES-1:0] flush_w;

  assign run_active   = (state_q == RUN) && lock_s;
  assign redir_stage  = (redirect_stage_i > LAST_STAGE) ? LAST_STAGE : redirect_stage_i;
  assign redir_accept = run_active && redirect_valid_i && stall_en[redir_stage];

  generate
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      localparam logic [SW:0] IDX = (SW+1)'(i);
      assign stall_en[i]   = ~|stall_req_i[NUM_STAGES-1:i];
      assign redir_mask[i] = redir_accept && (IDX < {1'b0, redir_stage});
      assign en_w[i]       = run_active && (stall_en[i] || redir_mask[i]);
      if (i == 0) begin : g_first
        assign flush_w[i] = redir_mask[i];
      end else begin : g_rest
        assign flush_w[i] = redir_mask[i] | (en_w[i] & ~en_w[i-1]);
      end
    end
  endgenerate

  assign stage_en_o    = en_w;
  assign stage_flush_o = flush_w;
  assign core_reset_o  = core_reset_q;
  assign ctrl_state_o  = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_cycles_q;
  logic [PERF_W-1:0] perf_stalls_q;
  logic [PERF_W-1:0] perf_flushes_q;

  // Only reset_n clears these; lock-loss re-sequencing keeps the history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_q  <= '0;
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (run_active && ~&perf_cycles_q)
        perf_cycles_q <= perf_cycles_q + PERF_W'(1);
      if (run_active && ~&en_w && ~&perf_stalls_q)
        perf_stalls_q <= perf_stalls_q + PERF_W'(1);
      if (redir_accept && ~&perf_flushes_q)
        perf_flushes_q <= perf_flushes_q + PERF_W'(1);
    end
  end

  assign perf_cycles_o  = perf_cycles_q;
  assign perf_stalls_o  = perf_stalls_q;
  assign perf_flushes_o = perf_flushes_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_unit : self-checking bench for pipe_ctrl_unit (5 stages)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic [4:0] stall_req;
  logic       redirect_valid;
  logic [2:0] redirect_stage;
  logic       halt_req;
  logic       core_reset;
  logic [4:0] stage_en;
  logic [4:0] stage_flush;
  logic [1:0] ctrl_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.NUM_STAGES(5), .RST_HOLD_CYCLES(4)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pll_locked_i     (pll_locked),
    .stall_req_i      (stall_req),
    .redirect_valid_i (redirect_valid),
    .redirect_stage_i (redirect_stage),
    .halt_req_i       (halt_req),
    .core_reset_o     (core_reset),
    .stage_en_o       (stage_en),
    .stage_flush_o    (stage_flush),
    .ctrl_state_o     (ctrl_state)
  );

  // Reference: highest stalled stage k freezes 0..k; bubble enters k+1.
  function automatic void model(input logic [4:0] st, input logic rv, input logic [2:0] rs,
                                output logic [4:0] en, output logic [4:0] fl);
    int k;
    int r;
    k = -1;
    for (int i = 0; i < 5; i++) if (st[i]) k = i;
    en = (k < 0) ? 5'h1f : 5'(32'h1f & ~((32'd2 << k) - 32'd1));
    fl = (k >= 0 && k < 4) ? 5'(32'd1 << (k + 1)) : 5'h00;
    r  = (int'(rs) > 4) ? 4 : int'(rs);
    if (rv && r > k) begin
      en = 5'h1f;
      fl = 5'((32'd1 << r) - 32'd1);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; stall_req = 5'b10101;
    redirect_valid = 1'b1; redirect_stage = 3'd2; halt_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
    checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", ctrl_state); end
    checks++; if (stage_en !== 5'b0) begin failures++; $display("FAIL reset_en got=%b exp=00000", stage_en); end
    checks++; if (stage_flush !== 5'b0) begin failures++; $display("FAIL reset_flush got=%b exp=00000", stage_flush); end
  endtask

  task automatic test_power_up();
    int n;
    int hold_seen;
    tick();
    rst_n = 1'b1; stall_req = '0; redirect_valid = 1'b0; halt_req = 1'b0;
    for (int c = 1; c <= 10; c++) tick();
    pll_locked = 1'b1;
    n = 0; hold_seen = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 3 && ctrl_state == 2'd1) hold_seen = 1;
      if (core_reset == 1'b0) begin n = c; break; end
    end
    checks++; if (n != 7) begin failures++; $display("FAIL powerup_latency got=%0d exp=7", n); end
    checks++; if (hold_seen != 1) begin failures++; $display("FAIL powerup_hold_state got=%0d exp=1", hold_seen); end
    checks++; if (ctrl_state !== 2'd2) begin failures++; $display("FAIL powerup_run got=%0d exp=2", ctrl_state); end
  endtask

  task automatic test_directed();
    logic [4:0] t_st [3] = '{5'b00100, 5'b00000, 5'b01000};
    logic       t_rv [3] = '{1'b0, 1'b1, 1'b1};
    logic [4:0] t_en [3] = '{5'b11000, 5'b11111, 5'b10000};
    logic [4:0] t_fl [3] = '{5'b01000, 5'b00011, 5'b10000};
    for (int t = 0; t < 3; t++) begin
      tick();
      stall_req = t_st[t]; redirect_valid = t_rv[t]; redirect_stage = 3'd2;
      @(negedge clk);
      checks++; if (stage_en !== t_en[t]) begin failures++; $display("FAIL directed%0d_en got=%b exp=%b", t, stage_en, t_en[t]); end
      checks++; if (stage_flush !== t_fl[t]) begin failures++; $display("FAIL directed%0d_flush got=%b exp=%b", t, stage_flush, t_fl[t]); end
    end
  endtask

  task automatic test_stall_redirect_random();
    logic [4:0] exp_en, exp_fl;
    for (int t = 0; t < 200; t++) begin
      tick();
      case ($urandom_range(0, 3))
        0: stall_req = '0;
        1: stall_req = 5'(32'd1 << $urandom_range(0, 4));
        default: stall_req = 5'($urandom);
      endcase
      redirect_valid = 1'($urandom);
      redirect_stage = 3'($urandom_range(0, 7));
      @(negedge clk);
      model(stall_req, redirect_valid, redirect_stage, exp_en, exp_fl);
      checks++; if (stage_en !== exp_en) begin failures++; $display("FAIL rand_en st=%b rv=%b rs=%0d got=%b exp=%b", stall_req, redirect_valid, redirect_stage, stage_en, exp_en); end
      checks++; if (stage_flush !== exp_fl) begin failures++; $display("FAIL rand_flush st=%b rv=%b rs=%0d got=%b exp=%b", stall_req, redirect_valid, redirect_stage, stage_flush, exp_fl); end
      checks++; if (ctrl_state !== 2'd2 || core_reset !== 1'b0) begin failures++; $display("FAIL rand_run state=%0d rst=%b exp=2/0", ctrl_state, core_reset); end
    end
  endtask

  task automatic test_lock_loss();
    int high;
    tick();
    pll_locked = 1'b0; stall_req = '0; redirect_valid = 1'b1; redirect_stage = 3'd2;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c < 2) begin
        checks++; if (stage_en !== 5'b11111 || stage_flush !== 5'b00011) begin failures++; $display("FAIL lockloss_pre%0d en=%b fl=%b exp=11111/00011", c, stage_en, stage_flush); end
      end else if (c == 2) begin
        checks++; if (stage_en !== 5'b0 || stage_flush !== 5'b0) begin failures++; $display("FAIL lockloss_suppress en=%b fl=%b exp=0/0", stage_en, stage_flush); end
      end else begin
        checks++; if (core_reset !== 1'b1 || ctrl_state !== 2'd0) begin failures++; $display("FAIL lockloss_reset rst=%b state=%0d exp=1/0", core_reset, ctrl_state); end
      end
      @(posedge clk); #1;
      if (c == 0) pll_locked = 1'b1;
    end
    redirect_valid = 1'b0;
    high = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (core_reset == 1'b0) break;
      checks++; if (stage_en !== 5'b0) begin failures++; $display("FAIL resequence_en got=%b exp=00000", stage_en); end
      high++;
      @(posedge clk); #1;
    end
    checks++; if (high != 5) begin failures++; $display("FAIL resequence_len got=%0d exp=5", high); end
    checks++; if (ctrl_state !== 2'd2) begin failures++; $display("FAIL resequence_run got=%0d exp=2", ctrl_state); end
  endtask

  task automatic test_halt_async_reset();
    tick();
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_stage = 3'd3; stall_req = '0;
    @(negedge clk);
    checks++; if (stage_en !== 5'b11111 || stage_flush !== 5'b00111) begin failures++; $display("FAIL halt_redirect en=%b fl=%b exp=11111/00111", stage_en, stage_flush); end
    for (int c = 0; c < 6; c++) begin
      tick();
      halt_req = 1'($urandom); redirect_valid = 1'($urandom);
      stall_req = 5'($urandom); redirect_stage = 3'($urandom);
      @(negedge clk);
      checks++; if (ctrl_state !== 2'd3 || stage_en !== 5'b0 || stage_flush !== 5'b0 || core_reset !== 1'b0) begin failures++; $display("FAIL halt_hold state=%0d en=%b fl=%b rst=%b exp=3/0/0/0", ctrl_state, stage_en, stage_flush, core_reset); end
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (ctrl_state !== 2'd0 || core_reset !== 1'b1 || stage_en !== 5'b0 || stage_flush !== 5'b0) begin failures++; $display("FAIL halt_async_reset state=%0d rst=%b en=%b fl=%b exp=0/1/0/0", ctrl_state, core_reset, stage_en, stage_flush); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_directed();
    test_stall_redirect_random();
    test_lock_loss();
    test_halt_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
